// File: rtl/timer_pkg.sv
// Shared definitions for the down-counter timer: FSM state encoding and default width.
package timer_pkg;

  localparam int unsigned N_PADRAO = 4;

  typedef enum logic [1:0] {
    ST_OCIOSO   = 2'b00,
    ST_CONTANDO = 2'b01,
    ST_PAUSADO  = 2'b10,
    ST_FIM      = 2'b11
  } estado_t;

endpackage

// File: rtl/contador_decrescente.sv
// N-bit down-counter datapath: load, decrement (saturating at zero), hold, ripple borrow.
module contador_decrescente #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         carrega,
  input  logic [N-1:0] valor,
  input  logic         decrementa,
  input  logic         ent,
  output logic [N-1:0] q,
  output logic         rbo
);

  // Count register; load wins over decrement, and zero never wraps.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (carrega) begin
      q <= valor;
    end else if (decrementa && (q != '0)) begin
      q <= q - N'(1);
    end
  end

  // Ripple borrow for cascading, gated by ent like the 74163 carry.
  assign rbo = ent && (q == '0);

endmodule

// File: rtl/timer_decrescente.sv
// Loadable down-counter timer with start/pause/expire FSM and cascade controls.
// Optional build macro TIMER_AUTO_RECARGA_EN: periodic reload instead of one-shot expiry.
module timer_decrescente
  import timer_pkg::*;
#(
  parameter int unsigned N = N_PADRAO
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] D,
  input  logic         iniciar,
  input  logic         pausar,
  input  logic         ent,
  input  logic         enp,
  output logic [N-1:0] Q,
  output logic         rbo,
  output logic         fim,
  output logic         ocupado,
  output logic [1:0]   db_estado
);

  estado_t      estado, estado_prox;
  logic [N-1:0] recarga, recarga_prox;
  logic         fim_prox;
  logic         carrega;
  logic [N-1:0] valor;
  logic         decrementa;
  logic         habilitado;
  logic         q_zero, q_um, recarga_zero;

  assign habilitado   = ent && enp;
  assign q_zero       = (Q == '0);
  assign q_um         = (Q == N'(1));
  assign recarga_zero = (recarga == '0);

  contador_decrescente #(.N(N)) u_contador (
    .clock      (clock),
    .clr        (clr),
    .carrega    (carrega),
    .valor      (valor),
    .decrementa (decrementa),
    .ent        (ent),
    .q          (Q),
    .rbo        (rbo)
  );

  // State, reload value and expiry pulse registers.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      estado  <= ST_OCIOSO;
      recarga <= '0;
      fim     <= 1'b0;
    end else begin
      estado  <= estado_prox;
      recarga <= recarga_prox;
      fim     <= fim_prox;
    end
  end

  // Next state and datapath controls; priority is ld > iniciar > pausar > enables.
  always_comb begin
    estado_prox  = estado;
    recarga_prox = recarga;
    fim_prox     = 1'b0;
    carrega      = 1'b0;
    valor        = recarga;
    decrementa   = 1'b0;

    if (!ld) begin
      carrega      = 1'b1;
      valor        = D;
      recarga_prox = D;
      estado_prox  = ST_OCIOSO;
    end else begin
      case (estado)
        ST_OCIOSO: begin
          if (iniciar) begin
            if (q_zero) begin
              estado_prox = ST_FIM;
              fim_prox    = 1'b1;
            end else begin
              estado_prox = ST_CONTANDO;
            end
          end
        end
        ST_CONTANDO: begin
          if (iniciar) begin
            carrega = 1'b1;
          end else if (pausar) begin
            estado_prox = ST_PAUSADO;
          end else if (habilitado) begin
`ifdef TIMER_AUTO_RECARGA_EN
            // Zero lasts one enabled cycle, then the period restarts.
            if (q_zero) begin
              carrega = 1'b1;
            end else begin
              decrementa = 1'b1;
              fim_prox   = q_um;
            end
`else
            if (q_zero) begin
              estado_prox = ST_FIM;
              fim_prox    = 1'b1;
            end else begin
              decrementa = 1'b1;
              if (q_um) begin
                estado_prox = ST_FIM;
                fim_prox    = 1'b1;
              end
            end
`endif
          end
        end
        ST_PAUSADO: begin
          if (!pausar) begin
            estado_prox = ST_CONTANDO;
          end
        end
        ST_FIM: begin
          if (iniciar) begin
            if (recarga_zero) begin
              fim_prox = 1'b1;
            end else begin
              carrega     = 1'b1;
              estado_prox = ST_CONTANDO;
            end
          end
        end
        default: begin
          estado_prox = ST_OCIOSO;
        end
      endcase
    end
  end

  assign ocupado   = (estado == ST_CONTANDO) || (estado == ST_PAUSADO);
  assign db_estado = estado;

endmodule
